// File: rtl/csi2_rx_depacketizer.sv
// CSI-2 RX depacketizer: parses lane-merged byte stream, checks header ECC, emits RAW16 pixels on AXI4-Stream.
// Optional payload CRC-16 check enabled by defining CSI2_RX_CRC_CHECK_EN.
`timescale 1ns/1ps
module csi2_rx_depacketizer #(
  parameter logic [1:0]  VC_ID    = 2'd0,
  parameter logic [5:0]  DT_PIXEL = 6'h2E,
  parameter logic [15:0] MAX_WC   = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        frame_active,
  output logic        frame_start,
  output logic        frame_end,
  output logic [15:0] line_count,
  output logic        ecc_err,
  output logic        crc_err,
  output logic        fmt_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {H0, H1, H2, H3, PAY, C0, C1} state_t;

  state_t             state, state_next;
  logic               s_hs;
  logic [BYTE_W-1:0]  di, wc_lo, wc_hi, lo_byte;
  logic [CNT_W-1:0]   wc, cnt;
  logic               pix_pkt, odd_byte, tuser_arm;
  logic               hdr_bad_c, is_short_c, vc_ok_c;

  // 6-bit Hamming parity over {WC_hi, WC_lo, DI}, bit 0 = DI[0]
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  assign s_axis_tready = (state == PAY) ? (!m_axis_tvalid || m_axis_tready) : 1'b1;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign wc            = {wc_hi, wc_lo};
  assign vc_ok_c       = (di[7:6] == VC_ID);
  assign is_short_c    = (di[5:0] < 6'h10);
  assign hdr_bad_c     = (ecc6({wc_hi, wc_lo, di}) != s_axis_tdata[5:0]) ||
                         (s_axis_tdata[7:6] != 2'b00) || (wc > MAX_WC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= H0;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      H0:  if (s_hs) state_next = H1;
      H1:  if (s_hs) state_next = H2;
      H2:  if (s_hs) state_next = H3;
      H3: begin
        if (s_hs) begin
          if (hdr_bad_c || is_short_c) state_next = H0;
          else if (wc == 16'd0)        state_next = C0;
          else                         state_next = PAY;
        end
      end
      PAY: if (s_hs && cnt == 16'd1) state_next = C0;
      C0:  if (s_hs) state_next = C1;
      C1:  if (s_hs) state_next = H0;
      default: state_next = H0;
    endcase
  end

  // Header capture, short-packet decode and pixel output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      di            <= '0;
      wc_lo         <= '0;
      wc_hi         <= '0;
      lo_byte       <= '0;
      cnt           <= '0;
      pix_pkt       <= 1'b0;
      odd_byte      <= 1'b0;
      tuser_arm     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_active  <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      line_count    <= '0;
      ecc_err       <= 1'b0;
      fmt_err       <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      ecc_err     <= 1'b0;
      fmt_err     <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        if (m_axis_tlast && line_count != 16'hFFFF) line_count <= line_count + 16'd1;
      end
      if (s_hs) begin
        case (state)
          H0: di    <= s_axis_tdata;
          H1: wc_lo <= s_axis_tdata;
          H2: wc_hi <= s_axis_tdata;
          H3: begin
            cnt      <= wc;
            odd_byte <= 1'b0;
            pix_pkt  <= vc_ok_c && (di[5:0] == DT_PIXEL);
            if (hdr_bad_c) begin
              ecc_err <= 1'b1;
            end else if (is_short_c && vc_ok_c) begin
              if (di[5:0] == 6'h00) begin
                frame_start  <= 1'b1;
                frame_active <= 1'b1;
                line_count   <= '0;
                tuser_arm    <= 1'b1;
              end else if (di[5:0] == 6'h01) begin
                frame_end    <= 1'b1;
                frame_active <= 1'b0;
              end
            end
          end
          PAY: begin
            cnt      <= cnt - 16'd1;
            odd_byte <= !odd_byte;
            if (!odd_byte) begin
              lo_byte <= s_axis_tdata;
            end else if (pix_pkt) begin
              // Remaining count <= 2 marks the last complete pixel for both even and odd WC
              m_axis_tdata  <= {s_axis_tdata, lo_byte};
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= (cnt <= 16'd2);
              m_axis_tuser  <= tuser_arm;
              tuser_arm     <= 1'b0;
            end
            if (cnt == 16'd1 && pix_pkt && wc[0]) fmt_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CSI2_RX_CRC_CHECK_EN
  logic [15:0]       crc;
  logic [BYTE_W-1:0] crc_lo;

  // Reflected CCITT CRC-16, LSB-first per byte
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc     <= 16'hFFFF;
      crc_lo  <= '0;
      crc_err <= 1'b0;
    end else begin
      crc_err <= 1'b0;
      if (s_hs) begin
        case (state)
          H3:      crc     <= 16'hFFFF;
          PAY:     crc     <= crc16_byte(crc, s_axis_tdata);
          C0:      crc_lo  <= s_axis_tdata;
          C1:      crc_err <= ({s_axis_tdata, crc_lo} != crc);
          default: ;
        endcase
      end
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_csi2_rx_depacketizer.sv
// Directed self-checking bench for csi2_rx_depacketizer (header ECC values hand-computed).
`timescale 1ns/1ps
module tb_csi2_rx_depacketizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        frame_active, frame_start, frame_end;
  logic [15:0] line_count;
  logic        ecc_err, crc_err, fmt_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] q_data[$];
  logic        q_last[$];
  logic        q_user[$];

`ifdef CSI2_RX_CRC_CHECK_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  csi2_rx_depacketizer dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frame_active(frame_active), .frame_start(frame_start), .frame_end(frame_end),
    .line_count(line_count), .ecc_err(ecc_err), .crc_err(crc_err), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  // Record every pixel handshake (signals are stable at the falling edge)
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_last.push_back(m_axis_tlast);
      q_user.push_back(m_axis_tuser);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC model: feedback enters at bit 15 with taps at bits 10 and 3
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r = {fb, r[15:1]};
      r[10] = r[10] ^ fb;
      r[3]  = r[3] ^ fb;
    end
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic acc;
    n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $error("FAIL s_accept_timeout observed=stalled expected=accept byte %h", b);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] di, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] ecc);
    send_byte(di);
    send_byte(lo);
    send_byte(hi);
    send_byte(ecc);
  endtask

  task automatic send_pay(input logic [7:0] p [4], input int n, input logic [15:0] flip,
                          output logic fmt_seen, output logic crc_seen);
    logic [15:0] c;
    c = 16'hFFFF;
    fmt_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = crc_byte(c, p[i]);
      send_byte(p[i]);
      if (i == n - 1) fmt_seen = fmt_err;
    end
    c = c ^ flip;
    send_byte(c[7:0]);
    send_byte(c[15:8]);
    crc_seen = crc_err;
  endtask

  task automatic expect_pix(input string tag, input logic [15:0] d, input logic l, input logic u);
    int n;
    logic [15:0] od;
    logic ol, ou;
    n = 0;
    while (q_data.size() == 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q_data.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=no_pixel expected=%h", tag, d);
    end else begin
      od = q_data.pop_front();
      ol = q_last.pop_front();
      ou = q_user.pop_front();
      chk({tag, "_data"}, 32'(od), 32'(d));
      chk({tag, "_last"}, 32'(ol), 32'(l));
      chk({tag, "_user"}, 32'(ou), 32'(u));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
    chk({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
    chk({tag, "_tuser"},  32'(m_axis_tuser),  32'd0);
    chk({tag, "_factive"}, 32'(frame_active), 32'd0);
    chk({tag, "_fstart"}, 32'(frame_start),   32'd0);
    chk({tag, "_fend"},   32'(frame_end),     32'd0);
    chk({tag, "_lines"},  32'(line_count),    32'd0);
    chk({tag, "_errs"},   32'({ecc_err, crc_err, fmt_err}), 32'd0);
    chk({tag, "_sready"}, 32'(s_axis_tready), 32'd1);
  endtask

  logic [7:0]  pay [4];
  logic        fmt_seen, crc_seen;
  logic [15:0] crc_good;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: frame start
    send_hdr(8'h00, 8'h00, 8'h00, 8'h00);
    chk("fs_pulse", 32'(frame_start), 32'd1);
    chk("fs_active", 32'(frame_active), 32'd1);
    chk("fs_lines", 32'(line_count), 32'd0);
    @(posedge clk);
    #1;
    chk("fs_pulse_end", 32'(frame_start), 32'd0);
    chk("fs_no_pix", 32'(m_axis_tvalid), 32'd0);

    // 2: RAW16 line, WC=4, good CRC
    pay = '{8'h34, 8'h12, 8'h78, 8'h56};
    send_hdr(8'h2E, 8'h04, 8'h00, 8'h3E);
    send_pay(pay, 4, 16'h0000, fmt_seen, crc_seen);
    chk("l1_fmt", 32'(fmt_seen), 32'd0);
    chk("l1_crc", 32'(crc_seen), 32'd0);
    chk("l1_lines", 32'(line_count), 32'd1);
    expect_pix("l1_p0", 16'h1234, 1'b0, 1'b1);
    expect_pix("l1_p1", 16'h5678, 1'b1, 1'b0);

    // 3: same line with downstream stall after first pixel
    crc_good = crc_byte(crc_byte(crc_byte(crc_byte(16'hFFFF, 8'h34), 8'h12), 8'h78), 8'h56);
    send_hdr(8'h2E, 8'h04, 8'h00, 8'h3E);
    send_byte(8'h34);
    m_axis_tready = 1'b0;
    send_byte(8'h12);
    chk("st_valid", 32'(m_axis_tvalid), 32'd1);
    s_axis_tdata  = 8'h78;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("st_sready", 32'(s_axis_tready), 32'd0);
      chk("st_hold", 32'({m_axis_tvalid, m_axis_tdata}), 32'h11234);
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(crc_good[7:0]);
    send_byte(crc_good[15:8]);
    chk("st_lines", 32'(line_count), 32'd2);
    expect_pix("st_p0", 16'h1234, 1'b0, 1'b0);
    expect_pix("st_p1", 16'h5678, 1'b1, 1'b0);

    // 4: FS with bad ECC, next byte must parse as DI of an FE
    send_hdr(8'h00, 8'h00, 8'h00, 8'h01);
    chk("ecc_pulse", 32'(ecc_err), 32'd1);
    chk("ecc_no_fs", 32'(frame_start), 32'd0);
    send_hdr(8'h01, 8'h00, 8'h00, 8'h07);
    chk("fe_pulse", 32'(frame_end), 32'd1);
    chk("fe_active", 32'(frame_active), 32'd0);

    // WC = 4098 > MAX_WC with valid ECC is a header error
    send_hdr(8'h2E, 8'h02, 8'h10, 8'h1E);
    chk("wc_big_err", 32'(ecc_err), 32'd1);
    send_hdr(8'h00, 8'h00, 8'h00, 8'h00);
    chk("wc_big_fs", 32'(frame_start), 32'd1);
    chk("fs2_lines", 32'(line_count), 32'd0);

    // 5: CRC hi byte corrupted
    pay = '{8'h34, 8'h12, 8'h78, 8'h56};
    send_hdr(8'h2E, 8'h04, 8'h00, 8'h3E);
    send_pay(pay, 4, 16'h0100, fmt_seen, crc_seen);
    chk("crc_bad", 32'(crc_seen), 32'(CRC_ON));
    @(posedge clk);
    #1;
    chk("crc_bad_once", 32'(crc_err), 32'd0);
    expect_pix("cb_p0", 16'h1234, 1'b0, 1'b1);
    expect_pix("cb_p1", 16'h5678, 1'b1, 1'b0);
    chk("cb_lines", 32'(line_count), 32'd1);

    // Odd WC=3: last byte dropped, tlast on the only pixel, fmt_err
    pay = '{8'hAA, 8'hBB, 8'hCC, 8'h00};
    send_hdr(8'h2E, 8'h03, 8'h00, 8'h1B);
    send_pay(pay, 3, 16'h0000, fmt_seen, crc_seen);
    chk("odd_fmt", 32'(fmt_seen), 32'd1);
    chk("odd_crc", 32'(crc_seen), 32'd0);
    expect_pix("odd_p0", 16'hBBAA, 1'b1, 1'b0);
    chk("odd_lines", 32'(line_count), 32'd2);

    // Non-pixel DT long packet: consumed, no output
    pay = '{8'h11, 8'h22, 8'h00, 8'h00};
    send_hdr(8'h2B, 8'h02, 8'h00, 8'h0B);
    send_pay(pay, 2, 16'h0000, fmt_seen, crc_seen);
    repeat (4) @(posedge clk);
    #1;
    chk("dt_no_pix", 32'(q_data.size()), 32'd0);
    chk("dt_lines", 32'(line_count), 32'd2);
    chk("dt_fmt", 32'(fmt_seen), 32'd0);

    // 6: reset mid-packet with a pixel pending, then FE
    m_axis_tready = 1'b0;
    send_hdr(8'h2E, 8'h04, 8'h00, 8'h3E);
    send_byte(8'h34);
    send_byte(8'h12);
    chk("rst_pre_valid", 32'(m_axis_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    send_hdr(8'h01, 8'h00, 8'h00, 8'h07);
    chk("rst_fe_pulse", 32'(frame_end), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_pix", 32'(q_data.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
